dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/load_align.sv | 22 ++
 rtl/dmem_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RISC-V width codes,
// controller states and byte-enable patterns.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DATA,
      WR_ACK,
      ERR_ACK
   } state_t;

   // Stores only support the signed width codes.
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      if (is_store) return f3 inside {F3_B, F3_H, F3_W};
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select and sign/zero extension of a RAM word.
module load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'(rdata >> {offset, 3'b000});
      half_v = offset[1] ? rdata[31:16] : rdata[15:0];
      case (funct3[1:0])
         2'b00:   data = funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
         2'b01:   data = funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between a core load/store port and a 2-cycle RAM.
// Optional boot-loader write port enabled by DMEM_LOADER_PORT_EN.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int MEMORY_SIZE = 12288,
   parameter int ADDR_WIDTH  = $clog2(MEMORY_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // Core request is taken in any cycle where req_valid && req_ready.
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [31:0]           rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [3:0]            mem_byteena,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
`ifdef DMEM_LOADER_PORT_EN
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [31:0]           ld_wdata,
`endif
   output state_t                dbg_state
);

   state_t      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] align_data;
   logic        req_fire;
   logic        fault;
   logic        misalign;
   logic        out_of_range;

`ifdef DMEM_LOADER_PORT_EN
   assign req_ready = (state_q == IDLE) && !ld_valid;
   assign ld_ready  = (state_q == IDLE);
`else
   assign req_ready = (state_q == IDLE);
`endif

   assign req_fire     = req_valid && req_ready;
   assign misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign out_of_range = 32'(req_addr) >= 32'(MEMORY_SIZE);
   assign fault        = !f3_legal(req_funct3, req_we) || misalign || out_of_range;

   load_align u_load_align (
      .rdata  (mem_rdata),
      .offset (addr_lo_q),
      .funct3 (funct3_q),
      .data   (align_data)
   );

   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      addr_lo_d   = addr_lo_q;
      rdata_d     = rdata_q;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_byteena = 4'b0000;
      mem_wdata   = 32'b0;
      case (state_q)
         IDLE: begin
`ifdef DMEM_LOADER_PORT_EN
            if (ld_valid) begin
               mem_addr    = ld_addr & ~ADDR_WIDTH'(3);
               mem_we      = 1'b1;
               mem_byteena = BE_W;
               mem_wdata   = ld_wdata;
            end
`endif
            if (req_fire) begin
               funct3_d  = req_funct3;
               addr_lo_d = req_addr[1:0];
               if (fault) begin
                  state_d = ERR_ACK;
               end else if (req_we) begin
                  mem_addr = req_addr;
                  mem_we   = 1'b1;
                  case (req_funct3[1:0])
                     2'b00: begin
                        mem_byteena = BE_B << req_addr[1:0];
                        mem_wdata   = {4{req_wdata[7:0]}};
                     end
                     2'b01: begin
                        mem_byteena = BE_H << req_addr[1:0];
                        mem_wdata   = {2{req_wdata[15:0]}};
                     end
                     default: begin
                        mem_byteena = BE_W;
                        mem_wdata   = req_wdata;
                     end
                  endcase
                  state_d = WR_ACK;
               end else begin
                  mem_addr = req_addr;
                  state_d  = RD_WAIT;
               end
            end
         end
         RD_WAIT: state_d = RD_DATA;
         RD_DATA: begin
            rdata_d = align_data;
            state_d = IDLE;
         end
         WR_ACK:  state_d = IDLE;
         ERR_ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Reset must never let a stray write reach the RAM.
      if (!rst_n) mem_we = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         funct3_q  <= 3'b000;
         addr_lo_q <= 2'b00;
         rdata_q   <= 32'b0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         addr_lo_q <= addr_lo_d;
         rdata_q   <= rdata_d;
      end
   end

   // Load data is only valid from the RAM during RD_DATA; hold it afterwards.
   assign rsp_valid = (state_q == RD_DATA) || (state_q == WR_ACK) || (state_q == ERR_ACK);
   assign rsp_err   = (state_q == ERR_ACK);
   assign rsp_rdata = (state_q == RD_DATA) ? align_data : rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: 2-cycle RAM model, byte-array reference memory,
// directed corner cases and randomized loads/stores.
module tb_dmem_ctrl;

   localparam int MS = 12288;
   localparam int AW = 14;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [2:0]        req_funct3 = 3'b000;
   logic [AW-1:0]     req_addr = '0;
   logic [31:0]       req_wdata = 32'b0;
   logic              rsp_valid;
   logic              rsp_err;
   logic [31:0]       rsp_rdata;
   logic [AW-1:0]     mem_addr;
   logic              mem_we;
   logic [3:0]        mem_byteena;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   dmem_pkg::state_t  dbg_state;
`ifdef DMEM_LOADER_PORT_EN
   logic              ld_valid = 1'b0;
   logic              ld_ready;
   logic [AW-1:0]     ld_addr = '0;
   logic [31:0]       ld_wdata = 32'b0;
`endif

   dmem_ctrl #(.MEMORY_SIZE(MS), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_rdata   (rsp_rdata),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_byteena (mem_byteena),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
`ifdef DMEM_LOADER_PORT_EN
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
`endif
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // RAM model: registered address, registered q
   logic        ram_clr = 1'b1;
   logic [31:0] ram [0:4095];
   logic [11:0] ram_addr_r;
   logic [31:0] ram_q;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 32'b0;
      end else if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_byteena[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      ram_addr_r <= mem_addr[13:2];
      ram_q      <= ram[ram_addr_r];
   end
   assign mem_rdata = ram_q;

   // reference model
   logic [7:0]  ref_mem [0:MS-1];
   logic [31:0] exp_q[$];
   logic [31:0] last_rd = 32'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic bit model_fault(input bit we, input bit [2:0] f3, input int addr);
      int size;
      if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
         return 1'b1;
      size = 1 << f3[1:0];
      if ((addr % size) != 0) return 1'b1;
      if (addr >= MS) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input bit [2:0] f3, input int addr);
      logic [31:0] v;
      int          size;
      v    = 32'b0;
      size = 1 << f3[1:0];
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[addr+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      return v;
   endfunction

   // driver: called and returns at posedge+1 with the controller idle
   task automatic do_req(input bit we, input bit [2:0] f3, input int addr, input logic [31:0] wd);
      bit          flt;
      int          size;
      int          lat;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      flt    = model_fault(we, f3, addr);
      size   = 1 << f3[1:0];
      exp_be = 4'b0;
      exp_wd = 32'b0;
      if (!flt && we) begin
         exp_be = 4'(((1 << size) - 1) << (addr % 4));
         case (size)
            1:       exp_wd = {4{wd[7:0]}};
            2:       exp_wd = {2{wd[15:0]}};
            default: exp_wd = wd;
         endcase
      end
      if (!flt && !we) exp_q.push_back(model_load(f3, addr));
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = AW'(addr);
      req_wdata  = wd;
      #1;
      check("accept_ready", req_ready, 1'b1);
      check("mem_we", mem_we, !flt && we);
      check("mem_byteena", mem_byteena, exp_be);
      check("mem_wdata", mem_wdata, exp_wd);
      check("mem_addr", mem_addr, flt ? 32'd0 : 32'(addr));
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!flt && we)
         for (int i = 0; i < size; i++) ref_mem[addr+i] = wd[8*i +: 8];
      lat = 1;
      while (!rsp_valid && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rsp_latency", lat, (!flt && !we) ? 2 : 1);
      check("rsp_err", rsp_err, flt);
      check("ready_in_rsp", req_ready, 1'b0);
      if (!flt && !we && exp_q.size() > 0) begin
         last_rd = exp_q.pop_front();
         check("rsp_rdata", rsp_rdata, last_rd);
      end
      @(posedge clk); #1;
      check("rsp_single_pulse", rsp_valid, 1'b0);
      check("ready_after_rsp", req_ready, 1'b1);
      check("rdata_hold", rsp_rdata, last_rd);
      check("err_low", rsp_err, 1'b0);
   endtask

   initial begin
      int accepts[$];
      int n_rsp;
      int seen;
      bit drop;

      for (int i = 0; i < MS; i++) ref_mem[i] = 8'h00;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_state", dbg_state, dmem_pkg::IDLE);
      ram_clr = 1'b0;
      rst_n   = 1'b1;
      @(posedge clk); #1;

      // word store and load back
      do_req(1, 3'b010, 'h100, 32'hDEAD_BEEF);
      do_req(0, 3'b010, 'h100, 32'h0);
      check("lw_deadbeef", last_rd, 32'hDEAD_BEEF);

      // byte store at lane 3, signed and unsigned byte loads
      do_req(1, 3'b000, 'h103, 32'h0000_00A5);
      do_req(0, 3'b000, 'h103, 32'h0);
      check("lb_a5", last_rd, 32'hFFFF_FFA5);
      do_req(0, 3'b100, 'h103, 32'h0);
      check("lbu_a5", last_rd, 32'h0000_00A5);

      // faults: misaligned, out of range, illegal store width
      do_req(0, 3'b001, 'h101, 32'h0);
      do_req(0, 3'b010, 'h3000, 32'h0);
      do_req(1, 3'b100, 'h104, 32'h1234_5678);
      do_req(0, 3'b011, 'h108, 32'h0);
      do_req(1, 3'b001, 'h2FFE, 32'hCAFE_8001);
      do_req(0, 3'b001, 'h2FFE, 32'h0);
      do_req(0, 3'b101, 'h2FFE, 32'h0);

      // reset during RD_WAIT abandons the load
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = AW'('h100);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("in_rd_wait", dbg_state, dmem_pkg::RD_WAIT);
      rst_n      = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_wdata  = 32'h5555_AAAA;
      #1;
      check("rst_async_state", dbg_state, dmem_pkg::IDLE);
      check("rst_hold_mem_we", mem_we, 1'b0);
      check("rst_rdata_clear", rsp_rdata, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst_n     = 1'b1;
      last_rd   = 32'h0;
      exp_q.delete();
      @(posedge clk); #1;
      check("ready_after_rst", req_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) seen++;
         @(posedge clk); #1;
      end
      check("no_rsp_after_rst", seen, 0);
      do_req(0, 3'b010, 'h100, 32'h0);

      // back-to-back loads with req_valid held high
      accepts.delete();
      n_rsp = 0;
      drop  = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = AW'('h100);
      #1;
      for (int cyc = 0; cyc < 30 && n_rsp < 4; cyc++) begin
         if (req_valid && req_ready) begin
            accepts.push_back(cyc);
            if (accepts.size() == 4) drop = 1'b1;
         end
         if (rsp_valid) begin
            n_rsp++;
            check("b2b_rdata", rsp_rdata, model_load(3'b010, 'h100));
         end
         @(posedge clk); #2;
         if (drop) req_valid = 1'b0;
      end
      check("b2b_rsp_count", n_rsp, 4);
      check("b2b_accept_count", accepts.size(), 4);
      for (int i = 1; i < accepts.size(); i++)
         check("b2b_spacing", accepts[i] - accepts[i-1], 3);
      last_rd = model_load(3'b010, 'h100);
      @(posedge clk); #1;

`ifdef DMEM_LOADER_PORT_EN
      // loader beats a simultaneous core request
      ld_valid   = 1'b1;
      ld_addr    = AW'('h207);
      ld_wdata   = 32'h1234_5678;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = AW'('h204);
      #1;
      check("ld_core_blocked", req_ready, 1'b0);
      check("ld_ready", ld_ready, 1'b1);
      check("ld_mem_we", mem_we, 1'b1);
      check("ld_byteena", mem_byteena, 4'b1111);
      check("ld_mem_addr", mem_addr, 32'h204);
      check("ld_mem_wdata", mem_wdata, 32'h1234_5678);
      @(posedge clk); #1;
      ld_valid = 1'b0;
      for (int i = 0; i < 4; i++) ref_mem['h204+i] = ld_wdata[8*i +: 8];
      check("ld_no_rsp", rsp_valid, 1'b0);
      do_req(0, 3'b010, 'h204, 32'h0);
      check("ld_readback", last_rd, 32'h1234_5678);
`endif

      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         int  a;
         bit  we;
         bit [2:0] f3;
         case ($urandom_range(0, 9))
            0:       a = $urandom_range(0, 16383);
            1:       a = $urandom_range(MS - 8, MS + 8);
            default: a = 'h200 + $urandom_range(0, 31);
         endcase
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         do_req(we, f3, a, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
